// File: rtl/demux_dispatcher.sv
// demux_dispatcher: accepts one item at a time from a single upstream port and
// delivers it to one of four downstream channels, either round-robin or to an
// explicitly addressed channel. Round-robin items that wait too long on a
// stalled channel move on to the next channel without dropping valid.
//
// Handshake: an item moves across a port on a rising edge where that port's
// valid and ready are both high. Upstream: in_valid/in_ready. Downstream:
// out_valid[sel]/out_ready[sel]. Once valid is raised, the payload and target
// stay put until the transfer, except when a round-robin item re-targets.
module demux_dispatcher #(
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              mode,
  input  logic [1:0]        in_dest,
  output logic [3:0]        out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic [3:0]        out_ready,
  output logic [1:0]        sel,
  output logic              busy,
  output logic [15:0]       sent_count,
  output logic [0:0]        dbg_state
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  // Wait counter is 8 bits wide because TIMEOUT tops out at 255.
  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  logic [0:0]        state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              mode_q, mode_d;
  logic [1:0]        sel_q, sel_d;
  logic [1:0]        rr_ptr_q, rr_ptr_d;
  logic [7:0]        wait_q, wait_d;
  logic [15:0]       sent_count_q, sent_count_d;

  logic deliver;

  // A held item is delivered only when the currently targeted channel is ready.
  assign deliver = (state_q == ST_SEND) && out_ready[sel_q];

  // Next-state logic: accept in IDLE, deliver or wait/re-target in SEND.
  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    mode_d       = mode_q;
    sel_d        = sel_q;
    rr_ptr_d     = rr_ptr_q;
    wait_d       = wait_q;
    sent_count_d = sent_count_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          data_d  = in_data;
          mode_d  = mode;
          sel_d   = mode ? in_dest : rr_ptr_q;
          wait_d  = 8'd0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (deliver) begin
          state_d      = ST_IDLE;
          sent_count_d = sent_count_q + 16'd1;
          // Directed items do not disturb the round-robin rotation.
          if (!mode_q) rr_ptr_d = sel_q + 2'd1;
        end else if (!mode_q && (wait_q == TIMEOUT_C)) begin
          sel_d  = sel_q + 2'd1;
          wait_d = 8'd0;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset discards any held item without counting it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      data_q       <= '0;
      mode_q       <= 1'b0;
      sel_q        <= 2'd0;
      rr_ptr_q     <= 2'd0;
      wait_q       <= 8'd0;
      sent_count_q <= 16'd0;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      mode_q       <= mode_d;
      sel_q        <= sel_d;
      rr_ptr_q     <= rr_ptr_d;
      wait_q       <= wait_d;
      sent_count_q <= sent_count_d;
    end
  end

  // Outputs are pure decodes of the registered state.
  always_comb begin
    in_ready   = (state_q == ST_IDLE);
    busy       = (state_q == ST_SEND);
    out_valid  = busy ? (4'b0001 << sel_q) : 4'b0000;
    out_data   = data_q;
    sel        = sel_q;
    sent_count = sent_count_q;
    dbg_state  = state_q;
  end

endmodule

// File: tb/tb_demux_dispatcher.sv
// Directed testbench for demux_dispatcher. Inputs are driven and outputs are
// sampled 1 ns after each rising edge.
module tb_demux_dispatcher;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        mode;
  logic [1:0]  in_dest;
  logic [3:0]  out_valid;
  logic [7:0]  out_data;
  logic [3:0]  out_ready;
  logic [1:0]  sel;
  logic        busy;
  logic [15:0] sent_count;
  logic [0:0]  dbg_state;

  int n_cmp;
  int n_err;
  logic [15:0] exp_count;

  demux_dispatcher #(.DATA_W(8), .TIMEOUT(15)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .mode       (mode),
    .in_dest    (in_dest),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .sel        (sel),
    .busy       (busy),
    .sent_count (sent_count),
    .dbg_state  (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one item for exactly one accept edge (DUT must be idle).
  task automatic send_item(input logic [7:0] d, input logic m, input logic [1:0] dst);
    in_valid = 1'b1;
    in_data  = d;
    mode     = m;
    in_dest  = dst;
    step();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    exp_count = 16'd0;
  endtask

  task automatic test_reset();
    in_valid  = 1'b0;
    in_data   = 8'h00;
    mode      = 1'b0;
    in_dest   = 2'd0;
    out_ready = 4'h0;
    do_reset();
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    n_cmp++; if (out_valid !== 4'b0000) begin n_err++; $display("FAIL reset_out_valid got=%b exp=0000", out_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (sel !== 2'd0) begin n_err++; $display("FAIL reset_sel got=%0d exp=0", sel); end
    n_cmp++; if (sent_count !== 16'd0) begin n_err++; $display("FAIL reset_count got=%h exp=0000", sent_count); end
    n_cmp++; if (out_data !== 8'h00) begin n_err++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
    n_cmp++; if (dbg_state !== 1'b0) begin n_err++; $display("FAIL reset_state got=%b exp=0", dbg_state); end
  endtask

  // Five round-robin items with all channels ready: channels 0,1,2,3,0.
  task automatic test_rr_sweep();
    logic [3:0] exp_v;
    logic [7:0] exp_d;
    out_ready = 4'hF;
    for (int i = 0; i < 5; i++) begin
      exp_d = 8'hA0 + 8'(i);
      exp_v = 4'b0001 << (i % 4);
      send_item(exp_d, 1'b0, 2'd3);
      n_cmp++; if (out_valid !== exp_v) begin n_err++; $display("FAIL rr_valid[%0d] got=%b exp=%b", i, out_valid, exp_v); end
      n_cmp++; if (out_data !== exp_d) begin n_err++; $display("FAIL rr_data[%0d] got=%h exp=%h", i, out_data, exp_d); end
      n_cmp++; if (in_ready !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL rr_busy[%0d] got in_ready=%b busy=%b exp 0/1", i, in_ready, busy); end
      step();
      exp_count++;
      n_cmp++; if (out_valid !== 4'b0000) begin n_err++; $display("FAIL rr_idle[%0d] got=%b exp=0000", i, out_valid); end
      n_cmp++; if (sent_count !== exp_count) begin n_err++; $display("FAIL rr_count[%0d] got=%0d exp=%0d", i, sent_count, exp_count); end
    end
  endtask

  // Directed item to channel 2 stalls 40 cycles, then delivers; rr_ptr stays 1.
  task automatic test_directed();
    out_ready = 4'h0;
    send_item(8'h5C, 1'b1, 2'd2);
    mode    = 1'b0;
    in_dest = 2'd0;
    for (int k = 0; k < 40; k++) begin
      n_cmp++; if (out_valid !== 4'b0100) begin n_err++; $display("FAIL dir_hold[%0d] got=%b exp=0100", k, out_valid); end
      step();
    end
    out_ready = 4'b0100;
    n_cmp++; if (out_valid !== 4'b0100 || out_data !== 8'h5C) begin n_err++; $display("FAIL dir_last got=%b/%h exp=0100/5c", out_valid, out_data); end
    step();
    exp_count++;
    n_cmp++; if (out_valid !== 4'b0000) begin n_err++; $display("FAIL dir_done got=%b exp=0000", out_valid); end
    n_cmp++; if (sent_count !== exp_count) begin n_err++; $display("FAIL dir_count got=%0d exp=%0d", sent_count, exp_count); end
    out_ready = 4'hF;
    send_item(8'h11, 1'b0, 2'd3);
    n_cmp++; if (sel !== 2'd1 || out_valid !== 4'b0010) begin n_err++; $display("FAIL dir_rr_ptr got sel=%0d valid=%b exp 1/0010", sel, out_valid); end
    step();
    exp_count++;
  endtask

  // rr_ptr=1, only channel 0 ready: item walks 1->2->3->0 in 16-cycle steps.
  task automatic test_timeout();
    logic [3:0] exp_v;
    do_reset();
    out_ready = 4'hF;
    send_item(8'h01, 1'b0, 2'd0);
    step();
    exp_count++;
    out_ready = 4'b0001;
    send_item(8'h3C, 1'b0, 2'd3);
    for (int ch = 1; ch < 4; ch++) begin
      exp_v = 4'b0001 << ch;
      for (int k = 0; k < 16; k++) begin
        n_cmp++; if (out_valid !== exp_v) begin n_err++; $display("FAIL to_valid[ch%0d,%0d] got=%b exp=%b", ch, k, out_valid, exp_v); end
        step();
      end
    end
    n_cmp++; if (out_valid !== 4'b0001 || sel !== 2'd0) begin n_err++; $display("FAIL to_wrap got=%b sel=%0d exp=0001 sel=0", out_valid, sel); end
    step();
    exp_count++;
    n_cmp++; if (sent_count !== exp_count || busy !== 1'b0) begin n_err++; $display("FAIL to_deliver got count=%0d busy=%b exp=%0d/0", sent_count, busy, exp_count); end
    out_ready = 4'hF;
    send_item(8'h22, 1'b0, 2'd0);
    n_cmp++; if (sel !== 2'd1) begin n_err++; $display("FAIL to_rr_ptr got=%0d exp=1", sel); end
    step();
    exp_count++;
  endtask

  // Reset while holding 0x77 discards it uncounted and resets rr_ptr.
  task automatic test_reset_mid();
    out_ready = 4'h0;
    send_item(8'h77, 1'b1, 2'd1);
    n_cmp++; if (busy !== 1'b1 || out_data !== 8'h77) begin n_err++; $display("FAIL mid_hold got busy=%b data=%h exp 1/77", busy, out_data); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_count = 16'd0;
    n_cmp++; if (out_valid !== 4'b0000 || busy !== 1'b0) begin n_err++; $display("FAIL mid_rst got valid=%b busy=%b exp 0000/0", out_valid, busy); end
    n_cmp++; if (in_ready !== 1'b1 || sent_count !== 16'd0) begin n_err++; $display("FAIL mid_rst2 got in_ready=%b count=%0d exp 1/0", in_ready, sent_count); end
    out_ready = 4'hF;
    send_item(8'h33, 1'b0, 2'd2);
    n_cmp++; if (sel !== 2'd0) begin n_err++; $display("FAIL mid_rr_ptr got=%0d exp=0", sel); end
    step();
    exp_count++;
  endtask

  // Readiness on other channels, or while idle, has no effect.
  task automatic test_ignored();
    out_ready = 4'h0;
    send_item(8'h9E, 1'b1, 2'd3);
    for (int k = 0; k < 8; k++) begin
      out_ready = 4'(k);
      step();
      n_cmp++; if (out_valid !== 4'b1000 || sent_count !== exp_count) begin n_err++; $display("FAIL ign_ready[%0d] got valid=%b count=%0d exp 1000/%0d", k, out_valid, sent_count, exp_count); end
    end
    out_ready = 4'b1000;
    step();
    exp_count++;
    n_cmp++; if (sent_count !== exp_count || busy !== 1'b0) begin n_err++; $display("FAIL ign_deliver got count=%0d busy=%b exp %0d/0", sent_count, busy, exp_count); end
    for (int k = 0; k < 4; k++) begin
      out_ready = 4'b0001 << k;
      step();
      n_cmp++; if (out_valid !== 4'b0000 || sent_count !== exp_count) begin n_err++; $display("FAIL ign_idle[%0d] got valid=%b count=%0d exp 0000/%0d", k, out_valid, sent_count, exp_count); end
    end
  endtask

  // Counter wrap from 0xFFFF to 0x0000.
  task automatic test_wrap();
    force dut.sent_count_q = 16'hFFFF;
    step();
    release dut.sent_count_q;
    step();
    n_cmp++; if (sent_count !== 16'hFFFF) begin n_err++; $display("FAIL wrap_preload got=%h exp=ffff", sent_count); end
    out_ready = 4'hF;
    send_item(8'h44, 1'b1, 2'd1);
    step();
    n_cmp++; if (sent_count !== 16'h0000) begin n_err++; $display("FAIL wrap got=%h exp=0000", sent_count); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    exp_count = 16'd0;
    rst = 1'b1;
    test_reset();
    test_rr_sweep();
    test_directed();
    test_timeout();
    test_reset_mid();
    test_ignored();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
